// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Tracks {rd index, write-enable, load flag} for DEPTH in-flight stages
//   behind decode (stage 0 = EX). It selects the youngest in-flight writer
//   as the forwarding source for rs/rt. It also detects load-use hazards
//   and injects the bubble into stage 0 itself.
//
//   Optional macro FWD_PERF_CNT_EN adds a saturating 16-bit counter of
//   hazard cycles (stall_cnt_o) with a synchronous clear (cnt_clr_i).
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   rd_n_i    destination index of the instruction leaving decode
//   rd_we_i   that instruction writes the register file
//   rd_ld_i   that instruction is a load
//   stall_i   external decode hold; bubble into stage 0
//   flush_i   kill the instruction leaving decode; bubble into stage 0
//   rs_n_i    rs index in decode
//   rt_n_i    rt index in decode
//   fw_rs_o   rs source: 0 = register file, k = stage k-1 result
//   fw_rt_o   rt source, same encoding
//   hazard_o  load-use hazard, decode must hold this cycle
//   stg_we_o  per-stage effective write-enable (registered)
//   stall_cnt_o, cnt_clr_i  only with FWD_PERF_CNT_EN
module fwd_hazard_unit #(
    parameter int RN_W  = 5,
    parameter int DEPTH = 3,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RN_W-1:0]  rd_n_i,
    input  logic             rd_we_i,
    input  logic             rd_ld_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [RN_W-1:0]  rs_n_i,
    input  logic [RN_W-1:0]  rt_n_i,
`ifdef FWD_PERF_CNT_EN
    input  logic             cnt_clr_i,
    output logic [15:0]      stall_cnt_o,
`endif
    output logic [SEL_W-1:0] fw_rs_o,
    output logic [SEL_W-1:0] fw_rt_o,
    output logic             hazard_o,
    output logic [DEPTH-1:0] stg_we_o
);

    logic [RN_W-1:0]  rn_q [DEPTH];
    logic [DEPTH-1:0] we_q;
    logic [DEPTH-1:0] ld_q;

    logic bubble;

    assign bubble = stall_i | flush_i | hazard_o;

    // Stage 0 takes the decode instruction or a bubble; older stages always advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                rn_q[k] <= '0;
            end
            we_q <= '0;
            ld_q <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                rn_q[k] <= rn_q[k-1];
                we_q[k] <= we_q[k-1];
                ld_q[k] <= ld_q[k-1];
            end
            if (bubble) begin
                rn_q[0] <= '0;
                we_q[0] <= 1'b0;
                ld_q[0] <= 1'b0;
            end else begin
                rn_q[0] <= rd_n_i;
                // Writes to register 0 are kept in the pipe but never forward.
                we_q[0] <= rd_we_i & (rd_n_i != '0);
                ld_q[0] <= rd_ld_i;
            end
        end
    end

    // Youngest matching stage wins; a load in stage 0 has no result yet.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [RN_W-1:0] src);
        logic [SEL_W-1:0] sel;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && we_q[k] && (rn_q[k] == src) && (src != '0) &&
                !((k == 0) && ld_q[0])) begin
                sel   = SEL_W'(k + 1);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fw_rs_o = fwd_sel(rs_n_i);
        fw_rt_o = fwd_sel(rt_n_i);
    end

    assign hazard_o = we_q[0] & ld_q[0] & (rn_q[0] != '0) &
                      ((rn_q[0] == rs_n_i) | (rn_q[0] == rt_n_i));

    assign stg_we_o = we_q;

`ifdef FWD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_q <= '0;
        end else if (hazard_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rd_n_i;
    logic       rd_we_i;
    logic       rd_ld_i;
    logic       stall_i;
    logic       flush_i;
    logic [4:0] rs_n_i;
    logic [4:0] rt_n_i;
    logic [2:0] fw_rs_o;
    logic [2:0] fw_rt_o;
    logic       hazard_o;
    logic [2:0] stg_we_o;
`ifdef FWD_PERF_CNT_EN
    logic        cnt_clr_i;
    logic [15:0] stall_cnt_o;
`endif

    fwd_hazard_unit #(
        .RN_W  (5),
        .DEPTH (3),
        .SEL_W (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_n_i   (rd_n_i),
        .rd_we_i  (rd_we_i),
        .rd_ld_i  (rd_ld_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .rs_n_i   (rs_n_i),
        .rt_n_i   (rt_n_i),
`ifdef FWD_PERF_CNT_EN
        .cnt_clr_i   (cnt_clr_i),
        .stall_cnt_o (stall_cnt_o),
`endif
        .fw_rs_o  (fw_rs_o),
        .fw_rt_o  (fw_rt_o),
        .hazard_o (hazard_o),
        .stg_we_o (stg_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       stall;
        logic       flush;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [2:0] e_rs;
        logic [2:0] e_rt;
        logic       e_hz;
        logic [2:0] e_stg;
    } vec_t;

    typedef struct packed {
        logic [2:0] fw_rs;
        logic [2:0] fw_rt;
        logic       hz;
        logic [2:0] stg;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t mk(input logic [4:0] rd, input logic we, input logic ld,
                                input logic st, input logic fl,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [2:0] e_rs, input logic [2:0] e_rt,
                                input logic e_hz, input logic [2:0] e_stg);
        vec_t v;
        v.rd = rd; v.we = we; v.ld = ld; v.stall = st; v.flush = fl;
        v.rs = rs; v.rt = rt;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_hz = e_hz; v.e_stg = e_stg;
        return v;
    endfunction

    task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                         input logic st, input logic fl,
                         input logic [4:0] rs, input logic [4:0] rt);
        rd_n_i = rd; rd_we_i = we; rd_ld_i = ld;
        stall_i = st; flush_i = fl; rs_n_i = rs; rt_n_i = rt;
    endtask

    task automatic check_outs(input string name, input exp_t e);
        n_total++;
        if (fw_rs_o === e.fw_rs && fw_rt_o === e.fw_rt &&
            hazard_o === e.hz && stg_we_o === e.stg) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rs=%0d rt=%0d hz=%0b we=%b, want rs=%0d rt=%0d hz=%0b we=%b",
                     name, fw_rs_o, fw_rt_o, hazard_o, stg_we_o,
                     e.fw_rs, e.fw_rt, e.hz, e.stg);
        end
    endtask

`ifdef FWD_PERF_CNT_EN
    task automatic check_cnt(input string name, input logic [15:0] e);
        n_total++;
        if (stall_cnt_o === e) n_pass++;
        else $display("FAIL %s: got %h want %h", name, stall_cnt_o, e);
    endtask

    task automatic one_hazard(input logic clr);
        @(negedge clk); drive(5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk); drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7);
        cnt_clr_i = clr;
        @(negedge clk); drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        cnt_clr_i = 1'b0;
    endtask
`endif

    initial begin
        exp_t e;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b0;
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
`ifdef FWD_PERF_CNT_EN
        cnt_clr_i = 1'b0;
`endif

        //           rd  we  ld  st  fl  rs  rt   ers ert hz  stg
        // single writer walking through the stages
        tbl.push_back(mk(5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,   1, 0, 0, 3'b001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,   2, 0, 0, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,   3, 0, 0, 3'b100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 3'b000));
        // load-use: one bubble, then forward from stage 1
        tbl.push_back(mk(7, 1, 1, 0, 0, 0, 0,   0, 0, 0, 3'b000));
        tbl.push_back(mk(4, 1, 0, 0, 0, 0, 7,   0, 0, 1, 3'b001));
        tbl.push_back(mk(4, 1, 0, 0, 0, 0, 7,   0, 2, 0, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 7,   1, 3, 0, 3'b101));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b100));
        // two writers of r3: youngest wins
        tbl.push_back(mk(3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000));
        tbl.push_back(mk(3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 3,   1, 1, 0, 3'b011));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 3,   2, 2, 0, 3'b110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 3,   3, 3, 0, 3'b100));
        // r0 write masked; flushed r9 never forwards
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000));
        tbl.push_back(mk(9, 1, 0, 0, 1, 0, 0,   0, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 9, 9,   0, 0, 0, 3'b000));
        // hazard + stall + flush together: still one bubble
        tbl.push_back(mk(6, 1, 1, 0, 0, 0, 0,   0, 0, 0, 3'b000));
        tbl.push_back(mk(8, 1, 0, 1, 1, 6, 0,   0, 0, 1, 3'b001));
        tbl.push_back(mk(8, 1, 0, 0, 0, 6, 0,   2, 0, 0, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 6, 8,   3, 1, 0, 3'b101));
        tbl.push_back(mk(2, 1, 0, 1, 0, 8, 0,   2, 0, 0, 3'b010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 8,   0, 3, 0, 3'b100));

        // reset state
        @(negedge clk);
        drive(5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
        #1;
        check_outs("reset_hold", '{fw_rs: 3'd0, fw_rt: 3'd0, hz: 1'b0, stg: 3'b000});
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].stall, tbl[i].flush,
                  tbl[i].rs, tbl[i].rt);
            sb.push_back('{fw_rs: tbl[i].e_rs, fw_rt: tbl[i].e_rt,
                           hz: tbl[i].e_hz, stg: tbl[i].e_stg});
            #2;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_empty: got 0 entries want 1");
            end else begin
                e = sb.pop_front();
                check_outs($sformatf("vec%0d", i), e);
            end
        end

        // asynchronous reset while entries are populated
        @(negedge clk); drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk); drive(5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk); drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd7);
        #1;
        check_outs("pre_rst", '{fw_rs: 3'd2, fw_rt: 3'd0, hz: 1'b1, stg: 3'b011});
        rst = 1'b0;
        #1;
        check_outs("in_rst", '{fw_rs: 3'd0, fw_rt: 3'd0, hz: 1'b0, stg: 3'b000});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("post_rst", '{fw_rs: 3'd0, fw_rt: 3'd0, hz: 1'b0, stg: 3'b000});
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

`ifdef FWD_PERF_CNT_EN
        check_cnt("cnt_reset", 16'd0);
        for (int h = 0; h < 3; h++) one_hazard(1'b0);
        check_cnt("cnt_three", 16'd3);
        one_hazard(1'b1);
        check_cnt("cnt_clr", 16'd0);
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        one_hazard(1'b0);
        check_cnt("cnt_to_max", 16'hFFFF);
        one_hazard(1'b0);
        check_cnt("cnt_sat", 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
